// File: rtl/pfx_pkg.sv
// Shared definitions for the prefix-sum blocks: state encoding, default sizes,
// and the index-width helper.
package pfx_pkg;

    localparam int PFX_IWIDTH = 8;
    localparam int PFX_V_LEN  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pfx_state_e;

    // A one-element vector still needs a one-bit index register.
    function automatic int pfx_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pfx_diff_if.sv
// Vector handshake bundle for pfx_diff. The element stream signals exist only
// when PFX_DIFF_STREAM_EN is defined.
interface pfx_diff_if #(
    parameter int IWIDTH = pfx_pkg::PFX_IWIDTH,
    parameter int V_LEN  = pfx_pkg::PFX_V_LEN
);
    logic                      valid_in;
    logic [IWIDTH*V_LEN-1:0]   ivec;
    logic                      ready;
    logic                      valid_out;
    logic [IWIDTH*V_LEN-1:0]   ovec;
`ifdef PFX_DIFF_STREAM_EN
    logic                      elem_valid;
    logic [IWIDTH-1:0]         elem_data;
`endif

    modport master (
        output valid_in,
        output ivec,
        input  ready,
        input  valid_out,
`ifdef PFX_DIFF_STREAM_EN
        input  elem_valid,
        input  elem_data,
`endif
        input  ovec
    );

    modport slave (
        input  valid_in,
        input  ivec,
        output ready,
        output valid_out,
`ifdef PFX_DIFF_STREAM_EN
        output elem_valid,
        output elem_data,
`endif
        output ovec
    );

endinterface

// File: rtl/pfx_diff.sv
// Prefix-sum inverter: one element difference per cycle, result published on
// completion. Optional per-element stream outputs under PFX_DIFF_STREAM_EN.
module pfx_diff
    import pfx_pkg::*;
#(
    parameter int IWIDTH = PFX_IWIDTH,
    parameter int V_LEN  = PFX_V_LEN
) (
    input  logic      clk,
    input  logic      rst_n,
    pfx_diff_if.slave bus
);

    localparam int VW    = IWIDTH * V_LEN;
    localparam int IDX_W = pfx_idx_width(V_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(V_LEN - 1);

    pfx_state_e        state_q, state_d;
    logic [VW-1:0]     cap_q, cap_d;
    logic [VW-1:0]     res_q, res_d;
    logic [VW-1:0]     ovec_q, ovec_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IWIDTH-1:0] prev_q, prev_d;
    logic              ready_q, ready_d;
    logic              vout_q, vout_d;
    logic [IWIDTH-1:0] cur_s, diff_s;

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        res_d   = res_q;
        ovec_d  = ovec_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        cur_s   = cap_q[int'(idx_q)*IWIDTH +: IWIDTH];
        diff_s  = cur_s - prev_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    state_d = ST_RUN;
                    cap_d   = bus.ivec;
                    idx_d   = {IDX_W{1'b0}};
                    prev_d  = {IWIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d[int'(idx_q)*IWIDTH +: IWIDTH] = diff_s;
                prev_d = cur_s;
                if (idx_q == LAST_IDX) begin
                    // Publish the whole vector at once so ovec never shows partials.
                    state_d = ST_DONE;
                    idx_d   = {IDX_W{1'b0}};
                    ovec_d  = res_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        vout_d  = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cap_q   <= {VW{1'b0}};
            res_q   <= {VW{1'b0}};
            ovec_q  <= {VW{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            prev_q  <= {IWIDTH{1'b0}};
            ready_q <= 1'b1;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
            ovec_q  <= ovec_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            ready_q <= ready_d;
            vout_q  <= vout_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.valid_out = vout_q;
    assign bus.ovec      = ovec_q;

`ifdef PFX_DIFF_STREAM_EN
    logic              elem_valid_q, elem_valid_d;
    logic [IWIDTH-1:0] elem_data_q, elem_data_d;

    // Precompute the element the upcoming RUN cycle produces
    always_comb begin
        elem_valid_d = (state_d == ST_RUN);
        if (elem_valid_d) begin
            elem_data_d = cap_d[int'(idx_d)*IWIDTH +: IWIDTH] - prev_d;
        end else begin
            elem_data_d = {IWIDTH{1'b0}};
        end
    end

    // Stream output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem_valid_q <= 1'b0;
            elem_data_q  <= {IWIDTH{1'b0}};
        end else begin
            elem_valid_q <= elem_valid_d;
            elem_data_q  <= elem_data_d;
        end
    end

    assign bus.elem_valid = elem_valid_q;
    assign bus.elem_data  = elem_data_q;
`endif

endmodule
